// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared scan-state enum, default geometry and PWM level helper
package panel_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } scan_state_e;

   localparam int DEF_COLS      = 64;
   localparam int DEF_SCAN_ROWS = 16;
   localparam int DEF_PWM_BITS  = 5;

   // Top level is reserved so that an all-ones pixel stays lit in every sub-period.
   function automatic int pwm_max_level(input int bits);
      return (1 << bits) - 2;
   endfunction

   localparam int PWM_MAX_LEVEL = pwm_max_level(DEF_PWM_BITS);

endpackage

// File: rtl/panel_slot_timer.sv
// rtl/panel_slot_timer.sv - column slot counter, panel_clk phase and fb_rd_en strobe
module panel_slot_timer
   import panel_pkg::*;
#(
   parameter int COLS    = DEF_COLS,
   parameter int CLK_DIV = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    active_d,
   input  logic                    start_d,
   output logic [$clog2(COLS)-1:0] slot,
   output logic                    slot_last,
   output logic                    panel_clk,
   output logic                    fb_rd_en
);

   localparam int SLOT_CYC = 2 * CLK_DIV;
   localparam int CYC_W    = $clog2(SLOT_CYC);
   localparam int COL_W    = $clog2(COLS);

   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [COL_W-1:0] slot_q, slot_d;
   logic             clk_q, clk_d;
   logic             rd_q, rd_d;

   always_comb begin
      cyc_d  = cyc_q;
      slot_d = slot_q;
      if (start_d) begin
         cyc_d  = '0;
         slot_d = '0;
      end else if (active_d) begin
         if (cyc_q == CYC_W'(SLOT_CYC - 1)) begin
            cyc_d  = '0;
            slot_d = (slot_q == COL_W'(COLS - 1)) ? slot_q : slot_q + 1'b1;
         end else begin
            cyc_d = cyc_q + 1'b1;
         end
      end
      // Outputs describe the coming cycle, so they are flops rather than decodes.
      clk_d = active_d && (cyc_d >= CYC_W'(CLK_DIV));
      rd_d  = active_d && (cyc_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q  <= '0;
         slot_q <= '0;
         clk_q  <= 1'b0;
         rd_q   <= 1'b0;
      end else begin
         cyc_q  <= cyc_d;
         slot_q <= slot_d;
         clk_q  <= clk_d;
         rd_q   <= rd_d;
      end
   end

   assign slot      = slot_q;
   assign slot_last = (cyc_q == CYC_W'(SLOT_CYC - 1)) && (slot_q == COL_W'(COLS - 1));
   assign panel_clk = clk_q;
   assign fb_rd_en  = rd_q;

endmodule

// File: rtl/panel_scan_ctrl.sv
// rtl/panel_scan_ctrl.sv - HUB75 scan controller: shift, blank, latch and display per PWM sub-period.
// PANEL_DBUF_EN adds swap_req/swap_ack/fb_buf_sel for frame-aligned double buffering.
module panel_scan_ctrl
   import panel_pkg::*;
#(
   parameter int COLS        = DEF_COLS,
   parameter int SCAN_ROWS   = DEF_SCAN_ROWS,
   parameter int PWM_BITS    = DEF_PWM_BITS,
   parameter int CLK_DIV     = 2,
   parameter int DISPLAY_CYC = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
`ifdef PANEL_DBUF_EN
   input  logic                         swap_req,
   output logic                         swap_ack,
   output logic                         fb_buf_sel,
`endif
   output logic                         fb_rd_en,
   output logic [$clog2(COLS)-1:0]      fb_col,
   output logic [$clog2(SCAN_ROWS)-1:0] fb_row,
   output logic [PWM_BITS-1:0]          pwm_level,
   output logic                         panel_clk,
   output logic                         panel_lat,
   output logic                         panel_oe,
   output logic [$clog2(SCAN_ROWS)-1:0] panel_addr,
   output logic                         frame_done
);

   localparam int ROW_W   = $clog2(SCAN_ROWS);
   localparam int DISP_W  = $clog2(DISPLAY_CYC + 1);
   localparam int MAX_LVL = pwm_max_level(PWM_BITS);

   scan_state_e        state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [DISP_W-1:0]  disp_q, disp_d;
   logic [ROW_W-1:0]   addr_q, addr_d;
   logic               lat_q, lat_d;
   logic               oe_q, oe_d;
   logic               fd_q, fd_d;
   logic               start_d;
   logic               slot_last;
   logic               disp_last, pwm_wrap, row_wrap;

   panel_slot_timer #(
      .COLS    (COLS),
      .CLK_DIV (CLK_DIV)
   ) u_slot_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .active_d  (state_d == ST_SHIFT),
      .start_d   (start_d),
      .slot      (fb_col),
      .slot_last (slot_last),
      .panel_clk (panel_clk),
      .fb_rd_en  (fb_rd_en)
   );

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      pwm_d     = pwm_q;
      disp_d    = disp_q;
      addr_d    = addr_q;
      start_d   = 1'b0;
      disp_last = (disp_q == DISP_W'(DISPLAY_CYC - 1));
      pwm_wrap  = (pwm_q == PWM_BITS'(MAX_LVL));
      row_wrap  = (row_q == ROW_W'(SCAN_ROWS - 1));
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_SHIFT;
               start_d = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (slot_last) state_d = ST_BLANK;
         end
         ST_BLANK: begin
            state_d = ST_LATCH;
            addr_d  = row_q;
         end
         ST_LATCH: begin
            state_d = ST_DISPLAY;
            disp_d  = '0;
         end
         ST_DISPLAY: begin
            if (disp_last) begin
               if (pwm_wrap) begin
                  pwm_d = '0;
                  row_d = row_wrap ? '0 : row_q + 1'b1;
               end else begin
                  pwm_d = pwm_q + 1'b1;
               end
               if (en) begin
                  state_d = ST_SHIFT;
                  start_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               disp_d = disp_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      lat_d = (state_d == ST_LATCH);
      oe_d  = (state_d != ST_DISPLAY);
      // Level and row are stable across DISPLAY, so the frame-end cycle is known one cycle ahead.
      fd_d  = (state_d == ST_DISPLAY) && (disp_d == DISP_W'(DISPLAY_CYC - 1)) && pwm_wrap && row_wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         pwm_q   <= '0;
         disp_q  <= '0;
         addr_q  <= '0;
         lat_q   <= 1'b0;
         oe_q    <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         pwm_q   <= pwm_d;
         disp_q  <= disp_d;
         addr_q  <= addr_d;
         lat_q   <= lat_d;
         oe_q    <= oe_d;
         fd_q    <= fd_d;
      end
   end

`ifdef PANEL_DBUF_EN
   logic buf_sel_q, buf_sel_d;
   logic ack_q, ack_d;

   always_comb begin
      ack_d     = fd_d && swap_req;
      buf_sel_d = buf_sel_q ^ ack_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_sel_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         buf_sel_q <= buf_sel_d;
         ack_q     <= ack_d;
      end
   end

   assign swap_ack   = ack_q;
   assign fb_buf_sel = buf_sel_q;
`endif

   assign fb_row     = row_q;
   assign pwm_level  = pwm_q;
   assign panel_lat  = lat_q;
   assign panel_oe   = oe_q;
   assign panel_addr = addr_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// tb/tb_panel_scan_ctrl.sv - self-checking bench for panel_scan_ctrl with a sub-period position model
module tb_panel_scan_ctrl;

   localparam int COLS  = 5;
   localparam int ROWS  = 3;
   localparam int PB    = 5;
   localparam int CD    = 3;
   localparam int DC    = 4;
   localparam int SL    = 2 * CD * COLS;
   localparam int SP    = SL + 2 + DC;
   localparam int NLVL  = 31;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       fb_rd_en;
   logic [2:0] fb_col;
   logic [1:0] fb_row;
   logic [4:0] pwm_level;
   logic       panel_clk;
   logic       panel_lat;
   logic       panel_oe;
   logic [1:0] panel_addr;
   logic       frame_done;
`ifdef PANEL_DBUF_EN
   logic       swap_req;
   logic       swap_ack;
   logic       fb_buf_sel;
`endif

   always #5 clk = ~clk;

   panel_scan_ctrl #(
      .COLS        (COLS),
      .SCAN_ROWS   (ROWS),
      .PWM_BITS    (PB),
      .CLK_DIV     (CD),
      .DISPLAY_CYC (DC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
`ifdef PANEL_DBUF_EN
      .swap_req   (swap_req),
      .swap_ack   (swap_ack),
      .fb_buf_sel (fb_buf_sel),
`endif
      .fb_rd_en   (fb_rd_en),
      .fb_col     (fb_col),
      .fb_row     (fb_row),
      .pwm_level  (pwm_level),
      .panel_clk  (panel_clk),
      .panel_lat  (panel_lat),
      .panel_oe   (panel_oe),
      .panel_addr (panel_addr),
      .frame_done (frame_done)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 20) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int row_of(input int k);
      return (k / NLVL) % ROWS;
   endfunction

   // Model: whether a sub-period is running, position p in it, sub-periods completed k.
   bit m_run = 0;
   int m_p = 0;
   int m_k = 0;
   int cyc = 0;

   bit measure = 0;
   bit prev_clk = 0, prev_oe = 1, seen_lat = 0, duty_on = 0, duty_done = 0;
   int last_rd = 0, rises = 0, last_lat = 0, low = 0, last_fd = -1, fd_cnt = 0;
   int on31 = 0, on0 = 0, on16 = 0, nsub = 0;

   always @(negedge clk) begin
      int e_pwm, e_row, e_rd, e_clk, e_lat, e_oe, e_col, e_addr, e_fd, ph;
      cyc++;
      if (!rst_n) begin
         chk("rst_oe", int'(panel_oe), 1);
         chk("rst_lat", int'(panel_lat), 0);
         chk("rst_pwm", int'(pwm_level), 0);
         chk("rst_row", int'(fb_row), 0);
         chk("rst_rd", int'(fb_rd_en), 0);
         m_run = 0; m_p = 0; m_k = 0;
      end else begin
         ph     = m_p % (2 * CD);
         e_pwm  = m_k % NLVL;
         e_row  = row_of(m_k);
         e_rd   = (m_run && m_p < SL && ph == 0) ? 1 : 0;
         e_clk  = (m_run && m_p < SL && ph >= CD) ? 1 : 0;
         e_lat  = (m_run && m_p == SL + 1) ? 1 : 0;
         e_oe   = (m_run && m_p >= SL + 2) ? 0 : 1;
         e_col  = (m_run && m_p < SL) ? m_p / (2 * CD) : ((m_run || m_k > 0) ? COLS - 1 : 0);
         e_addr = (m_run && m_p > SL) ? row_of(m_k) : ((m_k == 0) ? 0 : row_of(m_k - 1));
         e_fd   = (m_run && m_p == SP - 1 && e_pwm == NLVL - 1 && e_row == ROWS - 1) ? 1 : 0;
         chk("pwm_level", int'(pwm_level), e_pwm);
         chk("fb_row", int'(fb_row), e_row);
         chk("fb_rd_en", int'(fb_rd_en), e_rd);
         chk("panel_clk", int'(panel_clk), e_clk);
         chk("panel_lat", int'(panel_lat), e_lat);
         chk("panel_oe", int'(panel_oe), e_oe);
         chk("fb_col", int'(fb_col), e_col);
         chk("panel_addr", int'(panel_addr), e_addr);
         chk("frame_done", int'(frame_done), e_fd);

         if (frame_done) fd_cnt++;
         if (measure) begin
            if (panel_clk && !prev_clk) begin
               chk("rise_after_rd", cyc - last_rd, CD);
               rises++;
            end
            if (!panel_oe) low++;
            else if (!prev_oe) begin
               chk("oe_low_len", low, DC);
               low = 0;
            end
            if (panel_lat) begin
               if (seen_lat) begin
                  chk("rises_per_sub", rises, COLS);
                  chk("sub_len", cyc - last_lat, 36);
               end
               rises = 0; last_lat = cyc; seen_lat = 1;
               if (pwm_level == 0 && !duty_done) begin
                  duty_on = 1; on31 = 0; on0 = 0; on16 = 0; nsub = 0;
               end
               if (duty_on) begin
                  if (31 > int'(pwm_level)) on31++;
                  if (0 > int'(pwm_level)) on0++;
                  if (16 > int'(pwm_level)) on16++;
                  nsub++;
                  if (nsub == NLVL) begin
                     chk("duty_ff", on31, 31);
                     chk("duty_00", on0, 0);
                     chk("duty_80", on16, 16);
                     duty_on = 0; duty_done = 1;
                  end
               end
            end
            if (frame_done) begin
               if (last_fd >= 0) chk("frame_period", cyc - last_fd, 3348);
               last_fd = cyc;
            end
`ifdef PANEL_DBUF_EN
            chk("swap_ack", int'(swap_ack), int'(frame_done));
            chk("fb_buf_sel", int'(fb_buf_sel), fd_cnt % 2);
`endif
         end
         if (fb_rd_en) last_rd = cyc;
         prev_clk = panel_clk;
         prev_oe  = panel_oe;

         if (!m_run) begin
            if (en) begin m_run = 1; m_p = 0; end
         end else if (m_p == SP - 1) begin
            m_k++;
            if (en) m_p = 0;
            else m_run = 0;
         end else begin
            m_p++;
         end
      end
   end

   initial begin
      bit found;
      en = 1'b0;
      rst_n = 1'b0;
`ifdef PANEL_DBUF_EN
      swap_req = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("idle_rd", int'(fb_rd_en), 0);
      chk("idle_oe", int'(panel_oe), 1);

      measure = 1;
      en = 1'b1;
`ifdef PANEL_DBUF_EN
      repeat (700) @(posedge clk);
      #1 swap_req = 1'b1;
`endif
      for (int i = 0; i < 9000 && fd_cnt < 2; i++) @(posedge clk);
      chk("frames_seen", fd_cnt, 2);
      chk("duty_checked", int'(duty_done), 1);
      #1 measure = 0;

      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk);
         #1 if (fb_rd_en && fb_col == 3'd2) found = 1;
      end
      chk("find_col2", int'(found), 1);
      en = 1'b0;
      repeat (60) @(posedge clk);
      #1 chk("stopped_oe", int'(panel_oe), 1);
      chk("stopped_col", int'(fb_col), COLS - 1);

      en = 1'b1;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk);
         #1 if (!panel_oe) found = 1;
      end
      chk("find_display", int'(found), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      en = 1'b0;
      #1 chk("arst_oe", int'(panel_oe), 1);
      chk("arst_lat", int'(panel_lat), 0);
      chk("arst_pwm", int'(pwm_level), 0);
      chk("arst_row", int'(fb_row), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("post_rst_rd", int'(fb_rd_en), 0);
      chk("post_rst_oe", int'(panel_oe), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/panel_scan_ctrl.md
Name: panel_scan_ctrl

Overview:
- HUB75 scan controller, directly upstream of the panel_pwm comparator stage.
- Issues framebuffer read addresses (column/row), which select pix_top/pix_bottom for panel_pwm.
- Drives pwm_level, the 5-bit comparison level consumed by panel_pwm.
- Generates panel timing: shift clock, latch, output-enable and row address.
- Per row, cycles through 31 PWM sub-periods before advancing to the next row.

Parameters:
- COLS, 64, pixels shifted per row.
- SCAN_ROWS, 16, row-address count (panel height / 2).
- PWM_BITS, 5, pwm_level width; levels 0..2^PWM_BITS-2.
- CLK_DIV, 2, system cycles per panel_clk half period; legal range >= 2.
- DISPLAY_CYC, 8, system cycles panel_oe is held low per sub-period; legal range >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- fb_rd_en  out  1  framebuffer read strobe; RAM returns pix_top/pix_bottom one cycle later.
- fb_col  out  $clog2(COLS)  column read address.
- fb_row  out  $clog2(SCAN_ROWS)  row read address.
- pwm_level  out  PWM_BITS  level to panel_pwm.
- panel_clk  out  1  HUB75 CLK.
- panel_lat  out  1  HUB75 LAT.
- panel_oe  out  1  HUB75 OE, active-low.
- panel_addr  out  $clog2(SCAN_ROWS)  HUB75 A..D row address.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; panel_oe=1; all other outputs 0.
- IDLE:
  - Outputs hold; panel_oe=1.
  - en=1 -> SHIFT with column 0, slot counter 0.
- SHIFT: COLS slots, each 2*CLK_DIV cycles.
  - Slot cycle 0: fb_rd_en=1 for one cycle; fb_col = slot index.
  - panel_clk=0 for slot cycles 0..CLK_DIV-1, then 1 for cycles CLK_DIV..2*CLK_DIV-1.
  - RAM data and panel_pwm outputs are valid from slot cycle 1, so the rising edge is always at least one cycle after data-valid.
  - panel_oe=1 throughout SHIFT.
  - After the last cycle of slot COLS-1 -> BLANK.
- BLANK: 1 cycle; panel_oe=1, panel_clk=0; panel_addr <= fb_row. -> LATCH.
- LATCH: 1 cycle; panel_lat=1. -> DISPLAY.
- DISPLAY:
  - panel_oe=0 for exactly DISPLAY_CYC cycles.
  - On the final cycle, advance pwm_level; when pwm_level = 2^PWM_BITS-2 (30), wrap it to 0 and advance fb_row.
  - When fb_row wraps from SCAN_ROWS-1 to 0 together with a pwm_level wrap, assert frame_done for that cycle.
  - Then en=1 -> SHIFT; en=0 -> IDLE with panel_oe=1.
- pwm_level never reaches 31:
  - 31 sub-periods per row; pixel value v gives duty v/31.
  - Value 31 is fully on; 0 is fully off.
- Sub-period length = 2*CLK_DIV*COLS + 2 + DISPLAY_CYC cycles; 266 at defaults.
- en is sampled only in IDLE and on the last DISPLAY cycle; deassertion mid-row completes the current sub-period.
- fb_col holds COLS-1 after SHIFT and resets to 0 at the next SHIFT entry.
- Counter wrap-around uses explicit compare, not natural overflow, so non-power-of-2 COLS and SCAN_ROWS are legal.

Optional Feature:
- Macro: PANEL_DBUF_EN.
- Defined: adds ports swap_req (in, 1), swap_ack (out, 1) and fb_buf_sel (out, 1); all reset to 0.
  - A swap_req level seen high at frame end toggles fb_buf_sel in the same cycle as frame_done.
  - swap_ack pulses for one cycle in that cycle.
  - A request arriving mid-frame waits for the next frame end; tearing never occurs.
- Undefined: those ports are absent; a single buffer is used.

Decomposition:
- Package panel_pkg:
  - scan-state enum (IDLE, SHIFT, BLANK, LATCH, DISPLAY);
  - PWM_MAX_LEVEL = 2^PWM_BITS-2;
  - shared default constants for COLS and SCAN_ROWS.
- Sub-module panel_slot_timer: generates the slot counter, panel_clk phase and fb_rd_en strobe from CLK_DIV.

Test Plan:
- Reset mid-DISPLAY -> same cycle: panel_oe=1, panel_lat=0, pwm_level=0, fb_row=0; stays IDLE while en=0.
- en=1 at defaults -> exactly 64 panel_clk rising edges per sub-period.
  - Each rising edge at least 1 cycle after the fb_rd_en pulse for that column.
  - BLANK, then a 1-cycle panel_lat, then panel_oe low for exactly 8 cycles.
- Free run -> pwm_level steps 0..30 then wraps to 0; fb_row increments only on that wrap.
  - frame_done pulses once per 16*31 sub-periods, i.e. every 131936 cycles.
- Scoreboard with panel_pwm attached, pixel R=0xFF vs 0x00 -> r0 high in 31 of 31 sub-periods vs 0 of 31; R=0x80 (5-bit 16) -> 16 of 31.
- en dropped in mid-SHIFT -> current shift, latch and display complete, then IDLE with panel_oe=1; no further fb_rd_en.
- PANEL_DBUF_EN defined, swap_req pulsed mid-frame and held -> fb_buf_sel toggles and swap_ack pulses only in the frame_done cycle.
